// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter/sequencer between two clients and one shared multi-cycle mul/div unit.
// Latency: grant 1 cycle after req is sampled in IDLE; response 1 cycle after unit_valid (or after the watchdog expires).
// Backpressure: one operation in flight; req is held by the client until gnt, and later requests wait in IDLE.
module muldiv_arbiter #(
    parameter int unsigned TIMEOUT = 63,
    parameter int unsigned OP_MUL  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [2:0]  op0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [2:0]  op1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic [1:0]  gnt,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        unit_start,
    output logic [2:0]  unit_op,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic        unit_valid,
    input  logic [31:0] unit_result,
    output logic        busy,
    output logic        timeout_err
);

    // The watchdog is 6 bits wide and op codes are 3 bits wide; refuse parameters that cannot fit.
    if (TIMEOUT > 63) begin : g_bad_timeout
        $error("TIMEOUT must fit in the 6-bit watchdog");
    end
    if (OP_MUL > 7) begin : g_bad_op_mul
        $error("OP_MUL must fit in a 3-bit op code");
    end

    localparam logic [5:0] TO_CNT = 6'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic        owner_q, owner_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [5:0]  wd_q, wd_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        start_q, start_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        busy_q, busy_d;
    logic        timeout_err_q, timeout_err_d;
    logic        win;

    // Next-state and next-output decode; outputs are computed one cycle ahead so they leave a flop.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        wd_d          = wd_q;
        gnt_d         = 2'b00;
        start_d       = 1'b0;
        rsp_valid_d   = 2'b00;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = 1'b0;
        timeout_err_d = timeout_err_q;
        win           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    // Preferred client wins if it asks, otherwise the other one.
                    win        = req[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
                    owner_d    = win;
                    op_d       = win ? op1 : op0;
                    a_d        = win ? a1 : a0;
                    b_d        = win ? b1 : b0;
                    gnt_d[win] = 1'b1;
                    start_d    = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = 6'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (unit_valid) begin
                    rsp_data_d           = unit_result;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = S_RESP;
                end else if (wd_q == TO_CNT) begin
                    // Unit never answered: abort with an all-ones result and flag it.
                    rsp_data_d           = 32'hFFFF_FFFF;
                    rsp_err_d            = 1'b1;
                    timeout_err_d        = 1'b1;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = S_RESP;
                end else begin
                    wd_d = wd_q + 6'd1;
                end
            end
            S_RESP: begin
                // Hand priority to the client that was not just served.
                rr_ptr_d = ~owner_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, operand and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= 1'b0;
            owner_q       <= 1'b0;
            op_q          <= 3'd0;
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            wd_q          <= 6'd0;
            gnt_q         <= 2'b00;
            start_q       <= 1'b0;
            rsp_valid_q   <= 2'b00;
            rsp_data_q    <= 32'd0;
            rsp_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            wd_q          <= wd_d;
            gnt_q         <= gnt_d;
            start_q       <= start_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign gnt         = gnt_q;
    assign unit_start  = start_q;
    assign unit_op     = op_q;
    assign unit_a      = a_q;
    assign unit_b      = b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Bench for muldiv_arbiter: client drivers, a mul/div unit model and a response scoreboard.
// Latency: expects grant/response spacing of 12 (MUL), 42 (DIV), 65 (timeout) cycles.
// Backpressure: clients hold req until gnt; one operation is expected in flight at a time.
module tb_muldiv_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [1:0]  req;
    logic [2:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  gnt, rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err, unit_start;
    logic [2:0]  unit_op;
    logic [31:0] unit_a, unit_b;
    logic        unit_valid;
    logic [31:0] unit_result;
    logic        busy, timeout_err;

    assign req = {req1, req0};

    muldiv_arbiter #(.TIMEOUT(63), .OP_MUL(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .op0(op0), .a0(a0), .b0(b0), .op1(op1), .a1(a1), .b1(b1),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .unit_start(unit_start), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
        .unit_valid(unit_valid), .unit_result(unit_result),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic: op 2 multiplies, everything else divides; x/0 gives all ones.
    function automatic logic [31:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 3'd2) return a * b;
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
    endfunction

    typedef struct {
        logic [1:0]  g;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        e;
        int          lat;
        int          gap;
    } exp_t;

    exp_t expq[$];

    function automatic exp_t mk(input int c, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input int gap);
        exp_t x;
        x.g   = (c == 0) ? 2'b01 : 2'b10;
        x.op  = op;
        x.a   = a;
        x.b   = b;
        x.d   = calc(op, a, b);
        x.e   = 1'b0;
        x.lat = (op == 3'd2) ? 12 : 42;
        x.gap = gap;
        return x;
    endfunction

    // Unit model: answers 11 cycles after start for MUL, 41 for DIV, unless hung.
    bit hang = 1'b0;
    int stray_req = 0;
    int stray_ack = 0;
    int ucnt = 0;
    logic [31:0] ures = 32'd0;

    always @(posedge clk) begin
        #1;
        unit_valid = 1'b0;
        if (ucnt > 0) begin
            ucnt = ucnt - 1;
            if (ucnt == 0) begin
                unit_valid  = 1'b1;
                unit_result = ures;
            end
        end
        if (stray_req != stray_ack) begin
            stray_ack   = stray_req;
            unit_valid  = 1'b1;
            unit_result = 32'hDEAD_BEEF;
        end
        if (unit_start && !hang) begin
            ures = calc(unit_op, unit_a, unit_b);
            ucnt = (unit_op == 3'd2) ? 11 : 41;
        end
    end

    // Scoreboard: grants are checked against the head entry, responses pop it.
    int gnt_cyc = 0;
    int rsp_cyc = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
        end else begin
            if (gnt != 2'b00) begin
                if (expq.size() == 0) begin
                    chk("gnt_unexpected", {30'd0, gnt}, 32'd0);
                end else begin
                    chk("gnt", {30'd0, gnt}, {30'd0, expq[0].g});
                    chk("unit_start", {31'd0, unit_start}, 32'd1);
                    chk("unit_op", {29'd0, unit_op}, {29'd0, expq[0].op});
                    chk("unit_a", unit_a, expq[0].a);
                    chk("unit_b", unit_b, expq[0].b);
                    if (expq[0].gap > 0) chk("gnt_gap", 32'(cyc - rsp_cyc), 32'(expq[0].gap));
                end
                gnt_cyc = cyc;
            end else if (unit_start) begin
                chk("start_without_gnt", {31'd0, unit_start}, 32'd0);
            end
            if (rsp_valid != 2'b00) begin
                if (expq.size() == 0) begin
                    chk("rsp_unexpected", {30'd0, rsp_valid}, 32'd0);
                end else begin
                    exp_t x;
                    x = expq.pop_front();
                    chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, x.g});
                    chk("rsp_data", rsp_data, x.d);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, x.e});
                    chk("latency", 32'(cyc - gnt_cyc), 32'(x.lat));
                end
                rsp_cyc = cyc;
            end
        end
    end

    task automatic wait_gnt(input int c);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (gnt[c]) return;
        end
        chk("gnt_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic client_op(input int c, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input bit hold);
        @(posedge clk); #1;
        if (c == 0) begin op0 = op; a0 = a; b0 = b; req0 = 1'b1; end
        else        begin op1 = op; a1 = a; b1 = b; req1 = 1'b1; end
        wait_gnt(c);
        @(posedge clk); #1;
        if (!hold) begin
            if (c == 0) req0 = 1'b0;
            else        req1 = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (expq.size() == 0) begin
                @(negedge clk);
                return;
            end
        end
        chk("drain_timeout", 32'(expq.size()), 32'd0);
    endtask

    exp_t t;

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        op0 = 3'd0; a0 = 32'd0; b0 = 32'd0; op1 = 3'd0; a1 = 32'd0; b1 = 32'd0;
        unit_valid = 1'b0; unit_result = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_unit_start", {31'd0, unit_start}, 32'd0);
        chk("rst_unit_op", {29'd0, unit_op}, 32'd0);
        chk("rst_unit_a", unit_a, 32'd0);
        chk("rst_unit_b", unit_b, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        rst_n = 1'b1;

        // Contention from reset: strict alternation, client 0 first.
        expq.push_back(mk(0, 3'd2, 32'd3, 32'd5, 0));
        expq.push_back(mk(1, 3'd4, 32'd81, 32'd9, 2));
        expq.push_back(mk(0, 3'd5, 32'd1000, 32'd10, 2));
        expq.push_back(mk(1, 3'd4, 32'd77, 32'd0, 2));
        fork
            begin
                client_op(0, 3'd2, 32'd3, 32'd5, 1'b1);
                client_op(0, 3'd5, 32'd1000, 32'd10, 1'b0);
            end
            begin
                client_op(1, 3'd4, 32'd81, 32'd9, 1'b1);
                client_op(1, 3'd4, 32'd77, 32'd0, 1'b0);
            end
        join
        drain();

        // Single MUL on client 0, single DIV on client 1.
        expq.push_back(mk(0, 3'd2, 32'd7, 32'd6, 0));
        chk("model_mul", expq[0].d, 32'd42);
        client_op(0, 3'd2, 32'd7, 32'd6, 1'b0);
        drain();
        expq.push_back(mk(1, 3'd4, 32'd100, 32'd7, 0));
        chk("model_div", expq[0].d, 32'd14);
        client_op(1, 3'd4, 32'd100, 32'd7, 1'b0);
        drain();

        // Timeout: the unit never answers.
        hang = 1'b1;
        t = mk(0, 3'd2, 32'd2, 32'd3, 0);
        t.d = 32'hFFFF_FFFF; t.e = 1'b1; t.lat = 65;
        expq.push_back(t);
        client_op(0, 3'd2, 32'd2, 32'd3, 1'b0);
        drain();
        chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
        hang = 1'b0;
        expq.push_back(mk(1, 3'd2, 32'd4, 32'd4, 0));
        client_op(1, 3'd2, 32'd4, 32'd4, 1'b0);
        drain();
        chk("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);

        // Serve client 0 so the pointer favours client 1, then reset client 1's op mid-flight.
        expq.push_back(mk(0, 3'd2, 32'd9, 32'd9, 0));
        client_op(0, 3'd2, 32'd9, 32'd9, 1'b0);
        drain();
        expq.push_back(mk(1, 3'd4, 32'd500, 32'd5, 0));
        client_op(1, 3'd4, 32'd500, 32'd5, 1'b0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("midrst_unit_a", unit_a, 32'd0);
        chk("midrst_timeout_err", {31'd0, timeout_err}, 32'd0);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        chk("late_valid_busy", {31'd0, busy}, 32'd0);
        expq.push_back(mk(0, 3'd2, 32'd11, 32'd12, 0));
        expq.push_back(mk(1, 3'd6, 32'd99, 32'd3, 2));
        fork
            client_op(0, 3'd2, 32'd11, 32'd12, 1'b0);
            client_op(1, 3'd6, 32'd99, 32'd3, 1'b0);
        join
        drain();

        // Stray unit_valid in IDLE, and a request withdrawn before any edge samples it.
        stray_req = stray_req + 1;
        repeat (3) @(negedge clk);
        chk("stray_busy", {31'd0, busy}, 32'd0);
        chk("stray_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        op0 = 3'd2; a0 = 32'd1; b0 = 32'd1; req0 = 1'b1;
        #3 req0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("withdraw_busy", {31'd0, busy}, 32'd0);
        chk("withdraw_gnt", {30'd0, gnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout got %0d expected %0d", cyc, 0);
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/muldiv_arbiter.md
Name: muldiv_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared multi-cycle EXE multiply/divide unit. It accepts operation requests from two clients (e.g. the integer pipe and the accelerator port), issues one operation at a time to the unit, waits for the unit's completion pulse, and returns the result to the owning client. A watchdog guards against a unit that never completes.

Parameters:
TIMEOUT, 63, maximum cycles spent in WAIT before an operation is aborted (6-bit counter)
OP_MUL, 3'd2, op code the unit treats as multiply; every other code is a divide

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req  in  2  per-client request; held until the matching gnt bit is seen
op0  in  3  client 0 op code
a0  in  32  client 0 operand a
b0  in  32  client 0 operand b
op1  in  3  client 1 op code
a1  in  32  client 1 operand a
b1  in  32  client 1 operand b
gnt  out  2  one-cycle one-hot grant; operands are captured in this cycle
rsp_valid  out  2  one-cycle one-hot completion strobe
rsp_data  out  32  result, valid only while rsp_valid is nonzero
rsp_err  out  1  high with rsp_valid when the operation timed out
unit_start  out  1  one-cycle start pulse to the unit
unit_op  out  3  op code to the unit
unit_a  out  32  operand a to the unit
unit_b  out  32  operand b to the unit
unit_valid  in  1  unit completion pulse
unit_result  in  32  unit result, sampled when unit_valid is high
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky flag, set on any timeout, cleared only by reset

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; rr_ptr=0; all outputs 0; operand and owner registers 0; watchdog 0. Reset overrides any in-flight operation. A later stray unit_valid is ignored in IDLE.
- States:
  - IDLE: if any req bit is set, pick winner w and go to ISSUE. The winner is the set bit at rr_ptr, else the other set bit. Latch op_w, a_w and b_w into the op/a/b registers; owner<=w.
  - ISSUE: lasts one cycle. gnt[owner]=1 and unit_start=1. unit_op/a/b come from the registers and stay stable until the next ISSUE. Next state WAIT; watchdog<=0.
  - WAIT: if unit_valid=1, capture unit_result into rsp_data, clear the error flag, go to RESP. Else if watchdog==TIMEOUT, set rsp_data=32'hFFFF_FFFF, set the error flag and timeout_err=1, go to RESP. Else watchdog<=watchdog+1.
  - RESP: lasts one cycle. rsp_valid[owner]=1; rsp_err=error flag; rr_ptr<=~owner. Next state IDLE.
- Outputs gnt, unit_start, rsp_valid, rsp_err and busy are decoded from registered state only; they have no combinational path from req or unit_valid.
- Latency from req sampled in IDLE at cycle t:
  - ISSUE at t+1.
  - The unit asserts unit_valid at t+12 for MUL (11 cycles after start) and t+42 for DIV.
  - rsp_valid at t+13 for MUL, t+43 for DIV.
  - Back-to-back throughput: one operation per latency+1 cycles.
- Simultaneous requests: strict alternation. After a response, the other client has priority.
- A client may drop req in the same cycle it is sampled or later; a drop while in IDLE issues nothing. A req still high in the cycle after rsp_valid is treated as a new request. The client must deassert req in the cycle after gnt to avoid a repeat issue.
- unit_valid outside WAIT is ignored.
- Divide-by-zero is not trapped; the unit's result is passed through unchanged.
- Operands are not range-checked; all arithmetic is performed by the unit.

Test Plan:
- Single MUL: req=2'b01, op0=2, a0=7, b0=6 at t -> gnt=01 and unit_start at t+1; rsp_valid=01 at t+13 with rsp_data=42, rsp_err=0.
- Single DIV: req=2'b10, op1=4, a1=100, b1=7 -> gnt=10 at t+1; rsp_valid=10 at t+43 with rsp_data=14.
- Contention: both req held high from reset with two ops each -> gnt sequence 01,10,01,10. Each gnt follows the previous rsp_valid by 2 cycles. Data is routed to the correct owner.
- Timeout: unit model never pulses valid -> rsp_valid at ISSUE+65, rsp_data=FFFFFFFF, rsp_err=1, timeout_err stays 1 through the next good operation.
- Reset mid-operation: rst_n=0 during WAIT, then a late unit_valid -> all outputs 0, no rsp_valid. A following request completes normally with rr_ptr=0.
- Stray unit_valid while IDLE, and req withdrawn before sampling -> no gnt, no rsp_valid, state stays IDLE.
